usb_tx_arb: RTL

USB_TX_ARB -- requirements
Module: usb_tx_arb

---
 rtl/usb_tx_arb_if.sv | 25 ++
 rtl/usb_tx_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arb_if.sv
// usb_tx_arb_if -- beat-level transmit stream from the arbiter to the host.
//   master : arbiter side (drives valid/pid/data/len/sop/eop, samples ack)
//   slave  : host side (samples the beat, drives ack)
// A beat transfers on a rising clk edge where host_tx_valid && host_tx_ack.
interface usb_tx_arb_if;
  logic        host_tx_valid;
  logic [3:0]  host_tx_pid;
  logic [7:0]  host_tx_data;
  logic [15:0] host_tx_len;
  logic        host_tx_sop;
  logic        host_tx_eop;
  logic        host_tx_ack;

  modport master (
    output host_tx_valid, host_tx_pid, host_tx_data, host_tx_len,
           host_tx_sop, host_tx_eop,
    input  host_tx_ack
  );

  modport slave (
    input  host_tx_valid, host_tx_pid, host_tx_data, host_tx_len,
           host_tx_sop, host_tx_eop,
    output host_tx_ack
  );
endinterface

// File: rtl/usb_tx_arb.sv
// usb_tx_arb -- two-endpoint USB transmit arbiter.
// Picks one pending endpoint packet, streams its payload to the host one
// byte per accepted beat, then pulses that endpoint's tx_ready.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   epN_tx_req/pid/len : pending packet descriptor from endpoint N
//   epN_tx_byte        : payload byte at tx_rd_idx (combinational from buffer)
//   tx_rd_idx          : shared payload read index
//   epN_tx_ready       : one-cycle pulse when endpoint N's packet is sent
//   host               : beat stream to the host (usb_tx_arb_if.master)
//   busy, grant        : status; grant is one-hot, bit0 = EP0
// Configuration: define USB_TX_ARB_EP0_PRIO_EN for strict EP0 priority;
// otherwise ties are broken round-robin.
module usb_tx_arb #(
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ep0_tx_req,
  input  logic              ep1_tx_req,
  input  logic [3:0]        ep0_tx_pid,
  input  logic [3:0]        ep1_tx_pid,
  input  logic [15:0]       ep0_tx_len,
  input  logic [15:0]       ep1_tx_len,
  input  logic [7:0]        ep0_tx_byte,
  input  logic [7:0]        ep1_tx_byte,
  output logic [IDX_W-1:0]  tx_rd_idx,
  output logic              ep0_tx_ready,
  output logic              ep1_tx_ready,
  usb_tx_arb_if.master      host,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;      // 1: EP1 was granted last
  logic [3:0]       pid_q, pid_d;
  logic [15:0]      len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             busy_q, busy_d;
  logic [1:0]       rdy_q, rdy_d;

  logic [1:0]  pick;
  logic [3:0]  sel_pid;
  logic [15:0] sel_len, clamp_len, idx_nxt;
  logic        xfer;

  always_comb begin
    pick = 2'b00;
    if (ep0_tx_req && ep1_tx_req) begin
`ifdef USB_TX_ARB_EP0_PRIO_EN
      pick = 2'b01;
`else
      pick = last_q ? 2'b01 : 2'b10;
`endif
    end else if (ep0_tx_req) begin
      pick = 2'b01;
    end else if (ep1_tx_req) begin
      pick = 2'b10;
    end

    sel_pid   = grant_q[1] ? ep1_tx_pid : ep0_tx_pid;
    sel_len   = grant_q[1] ? ep1_tx_len : ep0_tx_len;
    clamp_len = (sel_len > MAX_LEN16) ? MAX_LEN16 : sel_len;
    xfer      = valid_q && host.host_tx_ack;
    idx_nxt   = 16'(idx_q) + 16'd1;

    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pid_d   = pid_q;
    len_d   = len_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    busy_d  = busy_q;
    rdy_d   = 2'b00;

    case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d = pick;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pid_d   = sel_pid;
        len_d   = clamp_len;
        idx_d   = '0;
        valid_d = 1'b1;
        sop_d   = 1'b1;
        // zero-length packets are a single sop+eop beat
        eop_d   = (clamp_len <= 16'd1);
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (eop_q) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            rdy_d   = grant_q;        // high for the whole DONE cycle
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            sop_d = 1'b0;
            eop_d = (idx_nxt == len_q - 16'd1);
          end
        end
      end
      DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      pid_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  // Payload byte comes straight from the endpoint buffer, so it follows
  // tx_rd_idx (held while ack is low); forced to 0 outside SEND and for ZLPs.
  always_comb begin
    host.host_tx_data = 8'h00;
    if (state_q == SEND && len_q != 16'd0)
      host.host_tx_data = grant_q[1] ? ep1_tx_byte : ep0_tx_byte;
  end

  assign host.host_tx_valid = valid_q;
  assign host.host_tx_pid   = pid_q;
  assign host.host_tx_len   = len_q;
  assign host.host_tx_sop   = sop_q;
  assign host.host_tx_eop   = eop_q;
  assign tx_rd_idx          = idx_q;
  assign ep0_tx_ready       = rdy_q[0];
  assign ep1_tx_ready       = rdy_q[1];
  assign busy               = busy_q;
  assign grant              = grant_q;

endmodule
